// File: rtl/xc_malu_sched_if.sv
// Bundle between two requesters, the response consumer and the multi-cycle ALU.
// The scheduler uses the slave modport; the environment uses master.
interface xc_malu_sched_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [5:0]  req_pw;
  logic [63:0] req_rs1;
  logic [63:0] req_rs2;
  logic [63:0] req_rs3;
  logic [1:0]  req_flush;
  logic        rsp_valid;
  logic        rsp_id;
  logic        rsp_err;
  logic [63:0] rsp_result;
  logic        rsp_ready;
  logic [31:0] malu_rs1;
  logic [31:0] malu_rs2;
  logic [31:0] malu_rs3;
  logic        malu_valid;
  logic        malu_flush;
  logic [13:0] malu_uop;
  logic [4:0]  malu_pw;
  logic [63:0] malu_result;
  logic        malu_ready;
  logic        busy;

  modport slave (
    input  req_valid, req_op, req_pw, req_rs1, req_rs2, req_rs3, req_flush,
    input  rsp_ready, malu_result, malu_ready,
    output req_ready, rsp_valid, rsp_id, rsp_err, rsp_result,
    output malu_rs1, malu_rs2, malu_rs3, malu_valid, malu_flush, malu_uop, malu_pw,
    output busy
  );

  modport master (
    output req_valid, req_op, req_pw, req_rs1, req_rs2, req_rs3, req_flush,
    output rsp_ready, malu_result, malu_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_err, rsp_result,
    input  malu_rs1, malu_rs2, malu_rs3, malu_valid, malu_flush, malu_uop, malu_pw,
    input  busy
  );
endinterface

// File: rtl/xc_malu_sched.sv
// Two-requester round-robin scheduler for a multi-cycle ALU with watchdog,
// owner flush and an IDLE/BUSY/RESP handshake FSM.
module xc_malu_sched #(
  parameter int TIMEOUT = 80
) (
  input logic           clock,
  input logic           reset,
  xc_malu_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic        last_q;
  logic [7:0]  wdog_q;
  logic [3:0]  op_q;
  logic [2:0]  pw_q;
  logic [31:0] rs1_q, rs2_q, rs3_q;
  logic        id_q;
  logic [63:0] res_q;
  logic        err_q;

  logic        gnt_any, gnt_id, legal, own_flush, timeout, in_busy, in_resp;
  logic [3:0]  sel_op;
  logic [2:0]  sel_pw;

  assign in_busy   = (state_q == BUSY);
  assign in_resp   = (state_q == RESP);
  assign gnt_any   = (state_q == IDLE) && (|bus.req_valid);
  // On a tie the requester that did not own the last operation wins.
  assign gnt_id    = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];
  assign sel_op    = gnt_id ? bus.req_op[7:4] : bus.req_op[3:0];
  assign sel_pw    = gnt_id ? bus.req_pw[5:3] : bus.req_pw[2:0];
  assign legal     = (sel_op < 4'd14) && (sel_pw < 3'd5);
  assign own_flush = bus.req_flush[id_q];
  assign timeout   = (wdog_q == WDOG_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      op_q    <= '0;
      pw_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs3_q   <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            op_q   <= sel_op;
            pw_q   <= sel_pw;
            rs1_q  <= gnt_id ? bus.req_rs1[63:32] : bus.req_rs1[31:0];
            rs2_q  <= gnt_id ? bus.req_rs2[63:32] : bus.req_rs2[31:0];
            rs3_q  <= gnt_id ? bus.req_rs3[63:32] : bus.req_rs3[31:0];
            id_q   <= gnt_id;
            wdog_q <= '0;
            if (legal) begin
              state_q <= BUSY;
            end else begin
              state_q <= RESP;
              err_q   <= 1'b1;
              res_q   <= '0;
            end
          end
        end
        BUSY: begin
          // Owner flush beats ALU completion, which beats the watchdog.
          if (own_flush) begin
            state_q <= IDLE;
            last_q  <= id_q;
          end else if (bus.malu_ready) begin
            res_q   <= bus.malu_result;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (timeout) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            wdog_q  <= wdog_q + 8'd1;
          end
        end
        RESP: begin
          if (own_flush || bus.rsp_ready) begin
            state_q <= IDLE;
            last_q  <= id_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant is combinational from req_valid, so it must be masked while reset is held.
  assign bus.req_ready  = (gnt_any && !reset) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  assign bus.malu_valid = in_busy;
  assign bus.malu_flush = in_busy && (own_flush || (!bus.malu_ready && timeout));
  assign bus.malu_uop   = in_busy ? (14'd1 << op_q) : 14'd0;
  assign bus.malu_pw    = in_busy ? (5'd1 << pw_q) : 5'd0;
  assign bus.malu_rs1   = rs1_q;
  assign bus.malu_rs2   = rs2_q;
  assign bus.malu_rs3   = rs3_q;

  assign bus.rsp_valid  = in_resp;
  assign bus.rsp_id     = in_resp && id_q;
  assign bus.rsp_err    = in_resp && err_q;
  assign bus.rsp_result = in_resp ? res_q : 64'd0;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_xc_malu_sched.sv
// Directed bench for xc_malu_sched: default-TIMEOUT instance for grant, flush,
// illegal-op and reset scenarios, TIMEOUT=4 instance for the watchdog.
module tb_xc_malu_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  xc_malu_sched_if bus ();
  xc_malu_sched_if bus4 ();

  xc_malu_sched u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  xc_malu_sched #(.TIMEOUT(4)) u_dut4 (
    .clock (clk),
    .reset (rst4),
    .bus   (bus4.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    bus.req_valid = 2'b11;
    bus.req_op = {4'd4, 4'd4};
    bus.req_pw = 6'd0;
    bus.req_rs1 = {32'd7, 32'd3};
    bus.req_rs2 = {32'd9, 32'd5};
    bus.req_rs3 = 64'd0;
    bus.req_flush = 2'b00;
    bus.rsp_ready = 1'b0;
    bus.malu_result = 64'd0;
    bus.malu_ready = 1'b0;
    bus4.req_valid = 2'b01;
    bus4.req_op = {4'd0, 4'd5};
    bus4.req_pw = {3'd0, 3'd2};
    bus4.req_rs1 = 64'd0;
    bus4.req_rs2 = 64'd0;
    bus4.req_rs3 = 64'd0;
    bus4.req_flush = 2'b00;
    bus4.rsp_ready = 1'b0;
    bus4.malu_result = 64'hdead_beef;
    bus4.malu_ready = 1'b0;

    // Reset held with both requesters valid: everything quiet.
    @(negedge clk); #1;
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_malu_flush", bus.malu_flush, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst4_req_ready", bus4.req_ready, 2'b00);

    // Tie after reset goes to requester 0; mul 3*5 finishing on BUSY cycle 33.
    @(negedge clk); rst = 1'b0; #1;
    chk("gnt0_ready", bus.req_ready, 2'b01);
    @(negedge clk); #1;
    chk("busy1_busy", bus.busy, 1'b1);
    chk("busy1_valid", bus.malu_valid, 1'b1);
    chk("busy1_uop", bus.malu_uop, 14'h0010);
    chk("busy1_pw", bus.malu_pw, 5'b00001);
    chk("busy1_rs1", bus.malu_rs1, 32'd3);
    chk("busy1_rs2", bus.malu_rs2, 32'd5);
    chk("busy1_ready", bus.req_ready, 2'b00);
    repeat (31) @(negedge clk);
    #1;
    chk("busy32_valid", bus.malu_valid, 1'b1);
    chk("busy32_uop", bus.malu_uop, 14'h0010);
    @(negedge clk);
    bus.malu_ready = 1'b1;
    bus.malu_result = 64'd15;
    @(negedge clk);
    bus.malu_ready = 1'b0;
    bus.malu_result = 64'd0;
    #1;
    chk("resp_valid", bus.rsp_valid, 1'b1);
    chk("resp_id", bus.rsp_id, 1'b0);
    chk("resp_result", bus.rsp_result, 64'd15);
    chk("resp_err", bus.rsp_err, 1'b0);
    chk("resp_malu_valid", bus.malu_valid, 1'b0);
    chk("resp_malu_uop", bus.malu_uop, 14'h0000);

    // Consumer stalls for 10 cycles: response holds, no new grant.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("stall_valid", bus.rsp_valid, 1'b1);
      chk("stall_id", bus.rsp_id, 1'b0);
      chk("stall_result", bus.rsp_result, 64'd15);
      chk("stall_req_ready", bus.req_ready, 2'b00);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    chk("idle_busy", bus.busy, 1'b0);
    chk("rr_gnt1_ready", bus.req_ready, 2'b10);

    // Requester 1 owns BUSY; non-owner flush ignored, owner flush with malu_ready wins.
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk("own1_rs1", bus.malu_rs1, 32'd7);
    chk("own1_busy", bus.busy, 1'b1);
    bus.req_flush = 2'b01;
    #1;
    chk("nonowner_flush", bus.malu_flush, 1'b0);
    @(negedge clk);
    bus.req_flush = 2'b00;
    #1;
    chk("nonowner_still_busy", bus.malu_valid, 1'b1);
    bus.req_flush = 2'b10;
    bus.malu_ready = 1'b1;
    bus.malu_result = 64'h1234;
    #1;
    chk("owner_flush", bus.malu_flush, 1'b1);
    @(negedge clk);
    bus.req_flush = 2'b00;
    bus.malu_ready = 1'b0;
    #1;
    chk("flush_idle", bus.busy, 1'b0);
    chk("flush_no_rsp", bus.rsp_valid, 1'b0);
    chk("flush_flush_gone", bus.malu_flush, 1'b0);

    // Illegal op 14 on requester 1.
    bus.req_op = {4'd14, 4'd4};
    bus.req_valid = 2'b10;
    #1;
    chk("ill_op_ready", bus.req_ready, 2'b10);
    chk("ill_op_no_issue", bus.malu_valid, 1'b0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk("ill_op_malu_valid", bus.malu_valid, 1'b0);
    chk("ill_op_rsp_valid", bus.rsp_valid, 1'b1);
    chk("ill_op_err", bus.rsp_err, 1'b1);
    chk("ill_op_result", bus.rsp_result, 64'd0);
    chk("ill_op_id", bus.rsp_id, 1'b1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // Illegal pw 5 on requester 0, then owner flush in RESP alongside rsp_ready.
    bus.req_op = {4'd0, 4'd0};
    bus.req_pw = {3'd1, 3'd5};
    bus.req_valid = 2'b01;
    #1;
    chk("ill_pw_ready", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk("ill_pw_rsp_valid", bus.rsp_valid, 1'b1);
    chk("ill_pw_err", bus.rsp_err, 1'b1);
    chk("ill_pw_id", bus.rsp_id, 1'b0);
    chk("ill_pw_malu_valid", bus.malu_valid, 1'b0);
    bus.req_flush = 2'b01;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_flush = 2'b00;
    bus.rsp_ready = 1'b0;
    #1;
    chk("resp_flush_idle", bus.busy, 1'b0);
    chk("resp_flush_no_rsp", bus.rsp_valid, 1'b0);

    // Flush in IDLE does not block grant; last owner was 0 so requester 1 wins.
    bus.req_pw = {3'd1, 3'd0};
    bus.req_valid = 2'b11;
    bus.req_flush = 2'b11;
    #1;
    chk("idle_flush_gnt", bus.req_ready, 2'b10);
    @(negedge clk);
    bus.req_flush = 2'b00;
    #1;
    chk("div_busy", bus.malu_valid, 1'b1);
    chk("div_uop", bus.malu_uop, 14'h0001);
    chk("div_pw", bus.malu_pw, 5'b00010);

    // Asynchronous reset between edges while BUSY.
    #2 rst = 1'b1;
    #1;
    chk("async_busy", bus.busy, 1'b0);
    chk("async_malu_valid", bus.malu_valid, 1'b0);
    chk("async_malu_uop", bus.malu_uop, 14'h0000);
    chk("async_malu_rs1", bus.malu_rs1, 32'd0);
    chk("async_req_ready", bus.req_ready, 2'b00);
    chk("async_malu_flush", bus.malu_flush, 1'b0);
    chk("async_rsp_valid", bus.rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_gnt", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;

    // TIMEOUT=4: watchdog flush on the 4th BUSY cycle.
    @(negedge clk);
    rst4 = 1'b0;
    #1;
    chk("t4_gnt", bus4.req_ready, 2'b01);
    @(negedge clk);
    bus4.req_valid = 2'b00;
    #1;
    chk("t4_uop", bus4.malu_uop, 14'h0020);
    chk("t4_pw", bus4.malu_pw, 5'b00100);
    chk("t4_c1_flush", bus4.malu_flush, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("t4_c3_flush", bus4.malu_flush, 1'b0);
    @(negedge clk); #1;
    chk("t4_c4_flush", bus4.malu_flush, 1'b1);
    @(negedge clk); #1;
    chk("t4_rsp_valid", bus4.rsp_valid, 1'b1);
    chk("t4_rsp_err", bus4.rsp_err, 1'b1);
    chk("t4_rsp_result", bus4.rsp_result, 64'd0);
    chk("t4_malu_valid", bus4.malu_valid, 1'b0);
    bus4.rsp_ready = 1'b1;
    @(negedge clk);
    bus4.rsp_ready = 1'b0;

    // malu_ready coinciding with the timeout cycle takes precedence.
    bus4.req_valid = 2'b01;
    @(negedge clk);
    bus4.req_valid = 2'b00;
    repeat (3) @(negedge clk);
    bus4.malu_ready = 1'b1;
    #1;
    chk("t4_coinc_flush", bus4.malu_flush, 1'b0);
    @(negedge clk);
    bus4.malu_ready = 1'b0;
    #1;
    chk("t4_coinc_valid", bus4.rsp_valid, 1'b1);
    chk("t4_coinc_err", bus4.rsp_err, 1'b0);
    chk("t4_coinc_result", bus4.rsp_result, 64'hdead_beef);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xc_malu_sched.md
XC_MALU_SCHED -- requirements
Module: xc_malu_sched

Interface
REQ-001 Parameter TIMEOUT, default 80, SHALL set the maximum number of BUSY cycles allowed before an operation is aborted; legal range 2..255.
REQ-002 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 req_valid  input  2  SHALL carry one request-valid bit per requester; bit i is requester i.
REQ-005 req_ready  output  2  SHALL carry one accept bit per requester.
REQ-006 req_op  input  8  SHALL carry a 4-bit op code per requester; requester i uses bits [4i+3:4i].
REQ-007 req_pw  input  6  SHALL carry a 3-bit pack-width code per requester; requester i uses bits [3i+2:3i].
REQ-008 req_rs1, req_rs2, req_rs3  input  64 each  SHALL carry the 32-bit operands per requester; requester i uses bits [32i+31:32i].
REQ-009 req_flush  input  2  SHALL carry one flush bit per requester.
REQ-010 rsp_valid, rsp_id, rsp_err  output  1, 1, 1  SHALL form the response handshake: valid flag, owning requester index, error flag.
REQ-011 rsp_result  output  64  SHALL carry the response data.
REQ-012 rsp_ready  input  1  SHALL signal that the consumer accepts the response.
REQ-013 malu_rs1, malu_rs2, malu_rs3  output  32 each  SHALL drive the latched operands to the ALU.
REQ-014 malu_valid, malu_flush  output  1 each  SHALL drive the ALU issue and abort controls.
REQ-015 malu_uop  output  14  SHALL drive a one-hot uop vector to the ALU, bit order [0..13] = div, divu, rem, remu, mul, mulu, mulsu, clmul, pmul, pclmul, madd, msub, macc, mmul.
REQ-016 malu_pw  output  5  SHALL drive the ALU pack width as {pw_2, pw_4, pw_8, pw_16, pw_32}.
REQ-017 malu_result  input  64  SHALL carry the ALU result.
REQ-018 malu_ready  input  1  SHALL carry the ALU done flag.
REQ-019 busy  output  1  SHALL indicate that the scheduler is not in IDLE.

Function
REQ-020 The scheduler SHALL use an FSM with states IDLE, BUSY and RESP.
REQ-021 Op codes 0..13 SHALL map to malu_uop bits 0..13; op codes 14 and 15 SHALL be illegal.
REQ-022 Pack-width codes 0..4 SHALL map to widths 32, 16, 8, 4 and 2; codes 5..7 SHALL be illegal.
REQ-023 In IDLE with any req_valid set, the scheduler SHALL grant by round robin: the requester not granted last wins a tie, and requester 0 has priority after reset.
REQ-024 The grant cycle SHALL assert req_ready for the granted requester only, combinationally, for exactly that one cycle.
REQ-025 On the grant edge the scheduler SHALL latch op, pw, operands and requester id into registers.
REQ-026 A legal grant SHALL transition IDLE to BUSY.
REQ-027 An illegal op or pw SHALL transition IDLE to RESP with rsp_err=1 and rsp_result=0, without asserting malu_valid.
REQ-028 In BUSY the scheduler SHALL hold malu_valid=1 and keep malu_uop, malu_pw and malu_rs1..3 stable from the latched registers.
REQ-029 Outside BUSY, malu_valid SHALL be 0 and malu_uop and malu_pw SHALL be all-zero.
REQ-030 In BUSY, malu_ready=1 SHALL capture malu_result into the response register, set rsp_err=0, and transition to RESP on the next edge.
REQ-031 A watchdog counter SHALL clear on entry to BUSY and increment on each BUSY cycle.
REQ-032 When the counter equals TIMEOUT-1 and malu_ready=0, the scheduler SHALL assert malu_flush for that cycle and transition to RESP with rsp_err=1 and rsp_result=0.
REQ-033 When malu_ready=1 and the timeout coincide, malu_ready SHALL take precedence.
REQ-034 In RESP the scheduler SHALL assert rsp_valid with the latched rsp_id, rsp_err and rsp_result held stable.
REQ-035 In RESP, rsp_ready=1 SHALL complete the transfer and transition to IDLE; the next grant is possible no earlier than the following cycle.
REQ-036 If req_flush for the owner is set in BUSY, the scheduler SHALL assert malu_flush combinationally in that cycle, go to IDLE, and produce no response.
REQ-037 Owner flush SHALL take precedence over a simultaneous malu_ready or timeout.
REQ-038 If req_flush for the owner is set in RESP, the scheduler SHALL drop the response and go to IDLE, even when rsp_ready is high in the same cycle.
REQ-039 A req_flush from a non-owner, or any req_flush in IDLE, SHALL have no effect on the scheduler.
REQ-040 A requester holding req_valid together with req_flush in IDLE SHALL still be eligible for grant.
REQ-041 The round-robin pointer SHALL update to the completed owner on any exit to IDLE: response taken, flush, or illegal-op response taken.
REQ-042 busy SHALL be 1 in BUSY and RESP and 0 in IDLE.

Reset
REQ-043 Asserting reset SHALL immediately force the FSM to IDLE, the round-robin pointer to "last=1", the watchdog counter to 0, and the latched registers to 0.
REQ-044 While reset is asserted, all outputs SHALL be 0, including malu_flush.
REQ-045 A reset during BUSY SHALL discard the operation without issuing a response; the ALU is reset by its own reset.

Verification
REQ-046 Both req_valid set after reset, op=4 (mul), pw=0, rs1=3, rs2=5, ALU ready after 33 cycles -> req_ready=01; rsp_id=0, rsp_result=15, rsp_err=0; requester 1 is granted in the first IDLE cycle after rsp_ready.
REQ-047 req_op=14 on requester 1 -> no malu_valid pulse; one cycle later rsp_valid=1, rsp_err=1, rsp_result=0, rsp_id=1.
REQ-048 Owner flush in the same cycle as malu_ready -> malu_flush=1 for one cycle; no rsp_valid; FSM returns to IDLE.
REQ-049 TIMEOUT=4 with malu_ready held 0 -> malu_flush in the 4th BUSY cycle; then rsp_err=1, rsp_result=0.
REQ-050 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_result stable throughout; req_ready stays 00.
REQ-051 Reset asserted mid-BUSY, asynchronously between clock edges -> outputs go to 0 before the next edge; the first grant after release goes to requester 0.
